// File: rtl/keypad_pkg.sv
// Shared key codes, FSM state type and key classification helpers.
package keypad_pkg;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_COMMIT
  } entry_state_t;

  function automatic logic is_digit(input logic [3:0] c);
    return c <= 4'd9;
  endfunction

  function automatic logic is_func(input logic [3:0] c);
    return (c >= KEY_A) && (c <= KEY_D);
  endfunction

endpackage

// File: rtl/key_event_detect.sv
// Turns the scanner's level-valid key code into one event per physical press.
module key_event_detect (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       evt,
  output logic [3:0] evt_code
);

  logic       kv_q;
  logic       armed;
  logic [3:0] code_q;

  // Register the key level and sample the code alongside it. kv_q resets
  // high so a key still held across reset cannot look like a release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kv_q   <= 1'b1;
      code_q <= 4'h0;
    end else begin
      kv_q   <= key_valid;
      code_q <= key_code;
    end
  end

  // Arm after one registered-low cycle; firing an event disarms.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        armed <= 1'b0;
    else if (evt)   armed <= 1'b0;
    else if (!kv_q) armed <= 1'b1;
  end

  assign evt      = kv_q & armed;
  assign evt_code = code_q;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer: BCD digit buffer, clear/commit, function keys,
// inactivity timeout, valid/ready hand-off of committed values.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           key_valid,
  input  logic [3:0]                     key_code,
  output logic [4*NUM_DIGITS-1:0]        entry_digits,
  output logic [$clog2(NUM_DIGITS+1)-1:0] entry_count,
  output logic [4*NUM_DIGITS-1:0]        value_out,
  output logic                           value_valid,
  input  logic                           value_ready,
  output logic [1:0]                     func_code,
  output logic                           func_pulse,
  output logic                           err_pulse,
  output logic                           timeout_pulse,
  output logic                           busy
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);

  logic          evt;
  logic [3:0]    evt_code;

  entry_state_t  state, state_n;
  logic [BW-1:0] dig_n, val_n;
  logic [CW-1:0] cnt_n;
  logic          vv_n, fp_n, ep_n, tp_n;
  logic [1:0]    fc_n;
  logic [TW-1:0] tcnt, tcnt_n;

  logic [BW+3:0] shift_full;
  logic [BW-1:0] dig_shift;

  key_event_detect u_evt (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .evt       (evt),
    .evt_code  (evt_code)
  );

  // Newest digit enters at the bottom; the oldest falls off the top.
  assign shift_full = {entry_digits, evt_code};
  assign dig_shift  = shift_full[BW-1:0];

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      entry_digits  <= '0;
      entry_count   <= '0;
      value_out     <= '0;
      value_valid   <= 1'b0;
      func_code     <= 2'd0;
      func_pulse    <= 1'b0;
      err_pulse     <= 1'b0;
      timeout_pulse <= 1'b0;
      tcnt          <= '0;
    end else begin
      state         <= state_n;
      entry_digits  <= dig_n;
      entry_count   <= cnt_n;
      value_out     <= val_n;
      value_valid   <= vv_n;
      func_code     <= fc_n;
      func_pulse    <= fp_n;
      err_pulse     <= ep_n;
      timeout_pulse <= tp_n;
      tcnt          <= tcnt_n;
    end
  end

  // Next-state and datapath decisions; the idle counter is held at zero
  // outside ENTRY so every entry into ENTRY starts a fresh window.
  always_comb begin
    state_n = state;
    dig_n   = entry_digits;
    cnt_n   = entry_count;
    val_n   = value_out;
    vv_n    = value_valid;
    fc_n    = func_code;
    fp_n    = 1'b0;
    ep_n    = 1'b0;
    tp_n    = 1'b0;
    tcnt_n  = '0;

    unique case (state)
      ST_IDLE: begin
        if (evt) begin
          if (is_digit(evt_code)) begin
            dig_n   = dig_shift;
            cnt_n   = CW'(1);
            state_n = ST_ENTRY;
          end else if (evt_code == KEY_HASH) begin
            ep_n = 1'b1;
          end else if (is_func(evt_code)) begin
            fp_n = 1'b1;
            fc_n = 2'(evt_code - KEY_A);
          end
        end
      end

      ST_ENTRY: begin
        if (evt) begin
          // Any key event restarts the idle window, even on the terminal cycle.
          if (is_digit(evt_code)) begin
            if (entry_count < CW'(NUM_DIGITS)) begin
              dig_n = dig_shift;
              cnt_n = entry_count + CW'(1);
            end else begin
              ep_n = 1'b1;
            end
          end else if (evt_code == KEY_STAR) begin
            dig_n   = '0;
            cnt_n   = '0;
            state_n = ST_IDLE;
          end else if (evt_code == KEY_HASH) begin
            val_n   = entry_digits;
            vv_n    = 1'b1;
            dig_n   = '0;
            cnt_n   = '0;
            state_n = ST_COMMIT;
          end else begin
            fp_n = 1'b1;
            fc_n = 2'(evt_code - KEY_A);
          end
        end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
          dig_n   = '0;
          cnt_n   = '0;
          tp_n    = 1'b1;
          state_n = ST_IDLE;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end

      ST_COMMIT: begin
        // Keys here are swallowed; only the consumer handshake moves on.
        if (value_ready) begin
          vv_n    = 1'b0;
          state_n = ST_IDLE;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl with scoreboards for committed
// values and function codes.
module tb_keypad_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic [15:0] entry_digits;
  logic [2:0]  entry_count;
  logic [15:0] value_out;
  logic        value_valid;
  logic        value_ready = 1'b0;
  logic [1:0]  func_code;
  logic        func_pulse, err_pulse, timeout_pulse, busy;

  int total = 0;
  int bad   = 0;
  int n_err = 0, n_fp = 0, n_tp = 0;

  logic [15:0] val_q[$];
  logic [1:0]  fc_q[$];

  keypad_entry_ctrl #(.NUM_DIGITS(4), .TIMEOUT_CYC(50)) dut (
    .clk           (clk),
    .rst           (rst),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .entry_digits  (entry_digits),
    .entry_count   (entry_count),
    .value_out     (value_out),
    .value_valid   (value_valid),
    .value_ready   (value_ready),
    .func_code     (func_code),
    .func_pulse    (func_pulse),
    .err_pulse     (err_pulse),
    .timeout_pulse (timeout_pulse),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Count strobe cycles just after each edge; a stretched strobe counts twice.
  always @(posedge clk) begin
    #1;
    if (err_pulse)     n_err++;
    if (func_pulse)    n_fp++;
    if (timeout_pulse) n_tp++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] c, input int hold, input int rel);
    key_code  = c;
    key_valid = 1'b1;
    repeat (hold) @(negedge clk);
    key_valid = 1'b0;
    repeat (rel) @(negedge clk);
  endtask

  // Wait for a commit, then pop the expected value and compare.
  task automatic wait_commit(input string tag);
    bit seen = 0;
    logic [15:0] e;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (value_valid) seen = 1;
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 32'(value_valid), 32'd1);
    end else if (val_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(val_q.size()), 32'd1);
    end else begin
      e = val_q.pop_front();
      chk(tag, 32'(value_out), 32'(e));
    end
  endtask

  task automatic check_func(input string tag);
    logic [1:0] e;
    if (fc_q.size() == 0) chk({tag, "_sb_empty"}, 32'(fc_q.size()), 32'd1);
    else begin
      e = fc_q.pop_front();
      chk(tag, 32'(func_code), 32'(e));
    end
  endtask

  initial begin
    int e0, t0, first;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_outputs", {entry_digits, value_out}, 32'h0);
    chk("rst_flags", {entry_count, value_valid, func_code, func_pulse,
                      err_pulse, timeout_pulse, busy}, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1,2,3 then '#', held consumer
    press(4'h1, 10, 5);
    press(4'h2, 10, 5);
    press(4'h3, 10, 5);
    chk("entry_123", 32'(entry_digits), 32'h0123);
    chk("count_3", 32'(entry_count), 32'd3);
    chk("busy_entry", 32'(busy), 32'd1);
    val_q.push_back(16'h0123);
    key_code = 4'hF; key_valid = 1'b1;
    wait_commit("commit_0123");
    chk("count_after_commit", 32'(entry_count), 32'd0);
    chk("digits_after_commit", 32'(entry_digits), 32'd0);
    key_valid = 1'b0;
    repeat (5) @(negedge clk);
    press(4'h8, 10, 5);   // dropped in COMMIT
    repeat (5) @(negedge clk);
    chk("vv_held", 32'(value_valid), 32'd1);
    chk("value_stable", 32'(value_out), 32'h0123);
    chk("commit_key_dropped", 32'(entry_count), 32'd0);
    value_ready = 1'b1;
    @(negedge clk);
    value_ready = 1'b0;
    chk("vv_drop", 32'(value_valid), 32'd0);
    chk("idle_after_hs", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);

    // Long hold of '5': one event, then timeout, no re-fire while held
    t0 = n_tp;
    key_code = 4'h5; key_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("hold_count1", 32'(entry_count), 32'd1);
    chk("hold_digits", 32'(entry_digits), 32'h0005);
    repeat (45) @(negedge clk);
    chk("hold_count_still1", 32'(entry_count), 32'd1);
    repeat (455) @(negedge clk);
    chk("hold_one_timeout", 32'(n_tp - t0), 32'd1);
    chk("hold_no_refire", 32'(entry_count), 32'd0);
    key_valid = 1'b0;
    repeat (5) @(negedge clk);

    // Overflow on the fifth digit, then clear
    press(4'h9, 10, 5);
    press(4'h8, 10, 5);
    press(4'h7, 10, 5);
    press(4'h6, 10, 5);
    e0 = n_err;
    press(4'h5, 10, 5);
    chk("ovf_err_once", 32'(n_err - e0), 32'd1);
    chk("ovf_digits", 32'(entry_digits), 32'h9876);
    chk("ovf_count", 32'(entry_count), 32'd4);
    press(4'hE, 10, 5);
    chk("star_count", 32'(entry_count), 32'd0);
    chk("star_digits", 32'(entry_digits), 32'd0);
    chk("star_busy", 32'(busy), 32'd0);

    // '#' from IDLE, function keys
    e0 = n_err;
    press(4'hF, 10, 5);
    chk("hash_idle_err", 32'(n_err - e0), 32'd1);
    chk("hash_idle_vv", 32'(value_valid), 32'd0);
    e0 = n_fp;
    fc_q.push_back(2'd2);
    press(4'hC, 10, 5);
    chk("func_c_pulse", 32'(n_fp - e0), 32'd1);
    check_func("func_c_code");
    press(4'h1, 10, 5);
    fc_q.push_back(2'd1);
    press(4'hB, 10, 5);
    check_func("func_b_code");
    chk("func_keeps_buf", 32'(entry_digits), 32'h0001);
    press(4'hE, 10, 5);

    // Timeout exactly TIMEOUT_CYC cycles after the event
    t0 = n_tp; first = -1;
    key_code = 4'h4; key_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("to_count1", 32'(entry_count), 32'd1);
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 10) key_valid = 1'b0;
      if (timeout_pulse && first < 0) first = n;
    end
    chk("to_cycle", 32'(first), 32'd50);
    chk("to_once", 32'(n_tp - t0), 32'd1);
    chk("to_buf_clr", 32'(entry_digits), 32'd0);
    chk("to_idle", 32'(busy), 32'd0);

    // Key event lands on the terminal cycle: key wins
    t0 = n_tp;
    key_code = 4'h4; key_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    for (int n = 1; n <= 55; n++) begin
      @(negedge clk);
      if (n == 10) key_valid = 1'b0;
      if (n == 48) begin key_code = 4'h7; key_valid = 1'b1; end
      if (n == 50) chk("race_no_tp", 32'(timeout_pulse), 32'd0);
      if (n == 53) key_valid = 1'b0;
    end
    chk("race_count2", 32'(entry_count), 32'd2);
    chk("race_digits", 32'(entry_digits), 32'h0047);
    chk("race_tp_none", 32'(n_tp - t0), 32'd0);
    press(4'hE, 10, 5);

    // Reset while committed and a key is held
    press(4'h4, 10, 5);
    val_q.push_back(16'h0004);
    key_code = 4'hF; key_valid = 1'b1;
    wait_commit("commit_0004");
    key_valid = 1'b0;
    repeat (5) @(negedge clk);
    key_code = 4'h6; key_valid = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_data", {entry_digits, value_out}, 32'h0);
    chk("arst_flags", {entry_count, value_valid, func_code, func_pulse,
                       err_pulse, timeout_pulse, busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("held_no_event", 32'(entry_count), 32'd0);
    chk("held_not_busy", 32'(busy), 32'd0);
    key_valid = 1'b0;
    repeat (5) @(negedge clk);
    press(4'h6, 10, 5);
    chk("repress_count", 32'(entry_count), 32'd1);
    chk("repress_digits", 32'(entry_digits), 32'h0006);

    chk("val_sb_drained", 32'(val_q.size()), 32'd0);
    chk("fc_sb_drained", 32'(fc_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
